hc595_rx: RTL

HC595_RX -- requirements
Module: hc595_rx

---
 rtl/hc595_pkg.sv | 18 +
 rtl/hc595_sync_edge.sv | 36 +++
 rtl/hc595_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
// Shared constants, state encoding and sizing helper for the 74HC595-style
// serial frame receiver.
package hc595_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 1000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hc595_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, plus a one-Clk rising-edge
// strobe taken from a registered copy of the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/hc595_rx.sv
// Receives frames from a serial 595 driver (SHCP shift clock, STCP latch clock,
// DS data, MSB first) and presents each latched frame on Data_out with a Valid pulse.
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             SHCP,
    input  logic             STCP,
    input  logic             DS,
    output logic [WIDTH-1:0] Data_out,
    output logic             Valid,
    output logic             Frame_err,
    output logic             Busy
);

    localparam int CNT_W = cnt_bits(WIDTH + 1);
    localparam int TMO_W = cnt_bits(TIMEOUT - 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic shcp_rise, stcp_rise, ds_sync;
    logic shcp_sync_unused, stcp_sync_unused, ds_rise_unused;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             timeout_hit;

    sync_edge u_shcp (
        .clk  (Clk),
        .rst_n(Reset_n),
        .d    (SHCP),
        .sync (shcp_sync_unused),
        .rise (shcp_rise)
    );

    sync_edge u_stcp (
        .clk  (Clk),
        .rst_n(Reset_n),
        .d    (STCP),
        .sync (stcp_sync_unused),
        .rise (stcp_rise)
    );

    // DS shares the synchronizer latency of SHCP, so it is aligned with the shift strobe.
    sync_edge u_ds (
        .clk  (Clk),
        .rst_n(Reset_n),
        .d    (DS),
        .sync (ds_sync),
        .rise (ds_rise_unused)
    );

    always_comb begin
        timeout_hit = (state_q == ST_SHIFT) && (tmo_q == TMO_LAST);
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (shcp_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shcp_rise)                      state_d = ST_SHIFT;
                else if (stcp_rise || timeout_hit)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: the latch always sees pre-shift contents and the pre-shift count,
    // matching a real 595 when both clocks rise together.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (stcp_rise) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = (cnt_q != CNT_FULL);
        end

        if (shcp_rise) begin
            shift_d = {shift_q[WIDTH-2:0], ds_sync};
            tmo_d   = '0;
            if (stcp_rise)             cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end else if (stcp_rise) begin
            cnt_d = '0;
            tmo_d = '0;
        end else if (timeout_hit) begin
            cnt_d = '0;
            tmo_d = '0;
        end else if (state_q == ST_SHIFT) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end
    end

    // FSM: state register and datapath flops
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // FSM: outputs
    always_comb begin
        Busy      = (state_q == ST_SHIFT);
        Data_out  = data_q;
        Valid     = valid_q;
        Frame_err = ferr_q;
    end

endmodule
